// File: rtl/zbt_pix_fetch_pkg.sv
// Shared raster geometry, ZBT widths and fetch FSM encoding.
// Also used by the edge stage and the bank-1 writer.
package zbt_pix_fetch_pkg;

  localparam int unsigned H_ACTIVE = 1024;
  localparam int unsigned V_ACTIVE = 768;
  localparam int unsigned ZBT_LAT  = 2;

  localparam int unsigned PIX_W  = 18;
  localparam int unsigned WORD_W = 2 * PIX_W;
  localparam int unsigned ADDR_W = 19;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] zaddr_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  // Word address of a pixel pair: line * words_per_line + pair index, modulo 2^19.
  function automatic zaddr_t word_addr(input logic [9:0] v, input logic [9:0] h_half,
                                       input int unsigned h_active);
    return zaddr_t'(v) * zaddr_t'(h_active / 2) + zaddr_t'(h_half);
  endfunction

endpackage

// File: rtl/zbt_lat_pipe.sv
// Fixed-depth shift pipe carrying {valid, word address} alongside an outstanding ZBT read.
module zbt_lat_pipe
  import zbt_pix_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = ZBT_LAT
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   valid_i,
  input  zaddr_t addr_i,
  output logic   valid_o,
  output zaddr_t addr_o
);

  logic [DEPTH-1:0] valid_q;
  zaddr_t           addr_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      addr_q[0]  <= addr_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign addr_o  = addr_q[DEPTH-1];

endmodule

// File: rtl/zbt_pix_fetch.sv
// Raster-driven ZBT bank-0 reader: one 36-bit word per even active pixel, returned
// data realigned with its word address for the edge stage.
module zbt_pix_fetch
  import zbt_pix_fetch_pkg::*;
#(
  parameter int unsigned H_ACT   = H_ACTIVE,
  parameter int unsigned V_ACT   = V_ACTIVE,
  parameter int unsigned LAT_CYC = ZBT_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [35:0] zbt_read_data,
  output logic [18:0] zbt_addr,
  output logic        zbt_we,
  output logic [35:0] two_pixel_vals,
  output logic [18:0] write_addr,
  output logic        pix_valid,
  output logic        frame_done
);

  localparam int unsigned CNT_W = (LAT_CYC > 1) ? $clog2(LAT_CYC) : 1;

  state_e     state_q;
  logic [CNT_W-1:0] drain_cnt_q;
  logic       left_line0_q;
  zaddr_t     zbt_addr_q;
  logic       frame_done_q;
  word_t      pix_q;
  zaddr_t     wr_addr_q;
  logic       pix_valid_q;

  logic       in_active;
  logic       at_origin;
  logic       raster_jump;
  logic       issue;
  logic       last_issue;
  zaddr_t     addr_a;
  logic       tail_valid;
  zaddr_t     tail_addr;

  always_comb begin
    addr_a      = word_addr(vcount, hcount[10:1], H_ACT);
    in_active   = (hcount < 11'(H_ACT)) && (vcount < 10'(V_ACT)) && !hcount[0];
    at_origin   = (hcount == '0) && (vcount == '0);
    // vcount can only return to 0 mid-frame through a raster resync.
    raster_jump = (vcount == '0) && left_line0_q;
    issue       = 1'b0;
    unique case (state_q)
      ST_IDLE:   issue = enable && at_origin;
      ST_ACTIVE: issue = in_active && !raster_jump;
      default:   issue = 1'b0;
    endcase
    last_issue  = issue && (hcount == 11'(H_ACT - 2)) && (vcount == 10'(V_ACT - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      drain_cnt_q  <= '0;
      left_line0_q <= 1'b0;
      zbt_addr_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (issue) zbt_addr_q <= addr_a;
      unique case (state_q)
        ST_IDLE: begin
          if (issue) begin
            state_q      <= ST_ACTIVE;
            left_line0_q <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (raster_jump) begin
            state_q <= ST_IDLE;
          end else if (last_issue) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= '0;
          end else if (vcount != '0) begin
            left_line0_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // Pulse lands together with the final pix_valid of the frame.
          if (drain_cnt_q == CNT_W'(LAT_CYC - 1)) begin
            frame_done_q <= 1'b1;
            state_q      <= ST_IDLE;
          end else begin
            drain_cnt_q <= drain_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  zbt_lat_pipe #(
    .DEPTH (LAT_CYC)
  ) u_pipe (
    .clk_i   (clk),
    .rst_ni  (reset),
    .valid_i (issue),
    .addr_i  (addr_a),
    .valid_o (tail_valid),
    .addr_o  (tail_addr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_q       <= '0;
      wr_addr_q   <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      pix_valid_q <= tail_valid;
      if (tail_valid) begin
        pix_q     <= zbt_read_data;
        wr_addr_q <= tail_addr;
      end
    end
  end

  assign zbt_addr       = zbt_addr_q;
  assign zbt_we         = 1'b0;
  assign two_pixel_vals = pix_q;
  assign write_addr     = wr_addr_q;
  assign pix_valid      = pix_valid_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_zbt_pix_fetch.sv
// Bench for zbt_pix_fetch on a reduced raster; expected outputs come from a frame-level
// reference model that schedules one output per issued read, LAT+1 cycles later.
module tb_zbt_pix_fetch;

  localparam int H   = 16;
  localparam int V   = 6;
  localparam int HT  = 24;
  localparam int VT  = 9;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [35:0] zbt_read_data;
  logic [18:0] zbt_addr;
  logic        zbt_we;
  logic [35:0] two_pixel_vals;
  logic [18:0] write_addr;
  logic        pix_valid;
  logic        frame_done;

  zbt_pix_fetch #(
    .H_ACT   (H),
    .V_ACT   (V),
    .LAT_CYC (LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .hcount         (hcount),
    .vcount         (vcount),
    .zbt_read_data  (zbt_read_data),
    .zbt_addr       (zbt_addr),
    .zbt_we         (zbt_we),
    .two_pixel_vals (two_pixel_vals),
    .write_addr     (write_addr),
    .pix_valid      (pix_valid),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [18:0] a;
  } exp_t;

  int tests = 0;
  int fails = 0;
  int h = 0, v = 0, cyc = 0;

  exp_t        q[$];
  bit          running;
  int          prev_v, done_at, idle_from;
  logic [18:0] exp_za, exp_wa, prev_za;
  logic [35:0] exp_pix;

  int          pv_since_fd = 0, last_frame_pv = -1, fd_seen = 0, pv_window = 0;
  bit          want_first = 0;
  logic [18:0] first_wa = '1;

  function automatic logic [35:0] data_of(input logic [18:0] a);
    return {a[17:0], ~a[17:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    q.delete();
    running   = 0;
    done_at   = -1;
    idle_from = 0;
    prev_v    = 0;
    exp_za    = '0;
    exp_wa    = '0;
    exp_pix   = '0;
  endtask

  // Decide what the current cycle's raster position should trigger.
  task automatic model_cycle();
    bit          iss;
    logic [18:0] a;
    iss = 0;
    if (!reset) begin
      model_clear();
      return;
    end
    if (!running) begin
      if (enable && h == 0 && v == 0 && cyc >= idle_from) begin
        running = 1;
        iss     = 1;
      end
    end else if (v == 0 && prev_v != 0) begin
      running = 0;
    end else if (h < H && v < V && (h % 2) == 0) begin
      iss = 1;
    end
    prev_v = v;
    if (iss) begin
      a = 19'((v * (H / 2) + h / 2) % (1 << 19));
      q.push_back('{cyc + LAT + 1, a});
      exp_za = a;
      if (h == H - 2 && v == V - 1) begin
        running   = 0;
        done_at   = cyc + LAT + 1;
        idle_from = cyc + LAT + 1;
      end
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    logic pv_e;
    logic fd_e;
    pv_e = 1'b0;
    fd_e = (done_at == cyc);
    if (q.size() > 0 && q[0].due == cyc) begin
      e       = q.pop_front();
      pv_e    = 1'b1;
      exp_wa  = e.a;
      exp_pix = data_of(e.a);
    end
    chk("pix_valid", pix_valid, pv_e);
    chk("frame_done", frame_done, fd_e);
    chk("write_addr", write_addr, exp_wa);
    chk("two_pixel_vals", two_pixel_vals, exp_pix);
    chk("zbt_addr", zbt_addr, exp_za);
    chk("zbt_we", zbt_we, 0);
    if (pix_valid === 1'b1) begin
      pv_since_fd++;
      pv_window++;
      if (want_first) begin
        first_wa   = write_addr;
        want_first = 0;
      end
    end
    if (frame_done === 1'b1) begin
      last_frame_pv = pv_since_fd;
      pv_since_fd   = 0;
      fd_seen++;
    end
  endtask

  task automatic drive_raster();
    hcount = 11'(h);
    vcount = 10'(v);
  endtask

  task automatic step();
    model_cycle();
    prev_za = zbt_addr;
    @(posedge clk);
    #1;
    cyc++;
    zbt_read_data = data_of(prev_za);
    check_outputs();
    h++;
    if (h == HT) begin
      h = 0;
      v++;
      if (v == VT) v = 0;
    end
    drive_raster();
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b0;
    #1;
    model_clear();
    pv_since_fd = 0;
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_write_addr", write_addr, 0);
    chk("rst_zbt_addr", zbt_addr, 0);
    chk("rst_two_pixel_vals", two_pixel_vals, 0);
    repeat (hold) step();
    reset      = 1'b1;
    want_first = 1;
  endtask

  initial begin
    int n;
    reset         = 1'b0;
    enable        = 1'b1;
    zbt_read_data = '0;
    model_clear();
    drive_raster();

    // Held in reset while the raster sweeps through the origin.
    repeat (40) step();
    reset      = 1'b1;
    want_first = 1;

    // Back-to-back frames with enable held high.
    n = 0;
    while (fd_seen < 3 && n < 1200) begin step(); n++; end
    chk("frames_done_3", fd_seen, 3);
    chk("frame_pix_count", last_frame_pv, H / 2 * V);
    chk("first_write_addr", first_wa, 0);

    // Drop enable part-way into a frame: it must still complete.
    n = 0;
    while (!(v == 2 && h == 0) && n < 400) begin step(); n++; end
    enable = 1'b0;
    n = 0;
    while (fd_seen < 4 && n < 400) begin step(); n++; end
    chk("enable_drop_done", fd_seen, 4);
    chk("enable_drop_pix_count", last_frame_pv, H / 2 * V);
    pv_window = 0;
    repeat (2 * HT * VT) step();
    chk("disabled_no_pix", pv_window, 0);

    // Reset in the middle of a frame, then restart from origin.
    enable = 1'b1;
    n = 0;
    while (!(v == 2 && h == 6 && running) && n < 800) begin step(); n++; end
    chk("reached_mid_frame", running, 1);
    do_reset(3);
    n = 0;
    while (fd_seen < 5 && n < 800) begin step(); n++; end
    chk("restart_done", fd_seen, 5);
    chk("restart_first_addr", first_wa, 0);
    chk("restart_pix_count", last_frame_pv, H / 2 * V);

    // Randomised enable, raster resyncs and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      if (running && $urandom_range(0, 199) == 0) begin
        v = 0;
        h = $urandom_range(1, HT - 1);
        drive_raster();
      end
      if ($urandom_range(0, 399) == 0) do_reset($urandom_range(1, 4));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
